dijkstra_relax_controller: RTL
==============================

Name: dijkstra_relax_controller

Overview:
- Sequencing stage that drives the distance priority queue. It initialises the queue for a source node and consumes the queue's min_index/min_value each round.
- Each round it marks the selected node visited, walks that node's adjacency row from an external synchronous weight memory, and writes relaxed distances back through the queue's set port.
- It owns the visited vector and a predecessor table, and signals done when every reachable node is settled.

Parameters:
- MAX_NODES, `DEFAULT_MAX_NODES, number of graph nodes
- INDEX_WIDTH, `DEFAULT_INDEX_WIDTH, node index width; 2**INDEX_WIDTH >= MAX_NODES
- VALUE_WIDTH, `DEFAULT_VALUE_WIDTH, distance/weight width; `INFINITY (all ones) means unreachable/no edge

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- source  in  INDEX_WIDTH  source node; sampled with start
- busy  out  1  high from INIT through DONE
- done  out  1  one-cycle pulse in DONE
- adj_row  out  INDEX_WIDTH  weight memory row (current node)
- adj_col  out  INDEX_WIDTH  weight memory column (neighbour)
- adj_weight  in  VALUE_WIDTH  weight at {adj_row,adj_col}, valid the cycle after the address
- pq_init  out  1  queue reset strobe; high only in INIT
- pq_set_en  out  1  queue write enable; always driven, never left floating
- pq_index  out  INDEX_WIDTH  queue access index
- pq_write_value  out  VALUE_WIDTH  relaxed distance
- pq_read_value  in  VALUE_WIDTH  queue distance at pq_index, combinational
- pq_min_index  in  INDEX_WIDTH  queue min over unvisited nodes
- pq_min_value  in  VALUE_WIDTH  distance of pq_min_index
- visited_vector  out  MAX_NODES  bit set = visited (`UNVISITED = 0)
- pred_index  in  INDEX_WIDTH  predecessor query address
- pred_value  out  INDEX_WIDTH  predecessor of pred_index, combinational

Behaviour:
- Reset (async, reset low) sets state IDLE and forces all of the following to 0: busy, done, pq_init, pq_set_en, pq_index, pq_write_value, adj_row, adj_col, visited_vector, and every pred entry. The queue contents are not touched.
- Reset asserted mid-run aborts immediately; no further queue writes occur.
- IDLE:
  - start=1 latches source and moves to INIT.
  - start while busy is ignored.
- INIT (1 cycle):
  - pq_init=1, pq_index=source.
  - visited cleared; all pred entries set to source.
  - Next state: SELECT.
- SELECT (1 cycle):
  - If all visited bits are set, or pq_min_value == `INFINITY, go to DONE.
  - Otherwise latch cur=pq_min_index and cur_dist=pq_min_value, set visited[cur], set nbr=0, and go to FETCH.
- FETCH (1 cycle):
  - adj_row=cur, adj_col=nbr.
  - Next state: RELAX.
- RELAX (1 cycle):
  - pq_index=nbr.
  - sum = cur_dist + adj_weight, computed at VALUE_WIDTH+1 bits.
  - Write condition: visited[nbr]==0, adj_weight != `INFINITY, sum < `INFINITY, and sum < pq_read_value.
  - When the condition holds: pq_set_en=1, pq_write_value=sum[VALUE_WIDTH-1:0], pred[nbr]=cur.
  - If nbr == MAX_NODES-1, go to SELECT; otherwise nbr++ and go to FETCH.
- Latency: 2 cycles per neighbour, so a round is 1+2*MAX_NODES cycles.
- DONE (1 cycle):
  - done=1, then return to IDLE.
  - visited_vector and pred hold until the next start.
- Self-loops and edges to already-visited nodes never write.
- Nodes that remain unreachable keep distance `INFINITY, visited=0, and pred=source.
- pq_set_en is 0 in every state except a qualifying RELAX cycle.

Decomposition:
- Shared package/constants: `INFINITY, `UNVISITED, DEFAULT_* widths, and the state enum {IDLE, INIT, SELECT, FETCH, RELAX, DONE}.
- Sub-module pred_table: MAX_NODES x INDEX_WIDTH register file with one write port (init-all, write-one) and one combinational read port.

Test Plan:
All scenarios use MAX_NODES=4, VALUE_WIDTH=8, and the weight memory modelled with 1-cycle read latency.
- Edges 0->1:4, 0->2:1, 2->1:2, 1->3:5, source 0 -> final distances {0,3,1,8}; pred {0,2,0,1}; visited 4'b1111; done in the 39th cycle after start is sampled.
- Same graph with the 1->3 edge removed -> run ends when pq_min_value==255; node 3 distance 255, visited[3]=0, pred[3]=0; exactly one done pulse.
- Edges 0->1:200, 1->2:100 -> sum 300 saturates; node 2 is never written and stays 255; pq_set_en never asserts with index 2.
- start pulsed again while busy, with source=3 -> ignored; results match the source-0 run.
- reset driven low during a RELAX cycle -> busy, pq_set_en and visited_vector go to 0 asynchronously. After release, a new start with source 2 completes correctly with distance[2]=0.
- Self-loop 0->0:1 plus 0->1:1 -> no write to index 0; distance[1]=1.

Source files
------------

// File: rtl/dijkstra_relax_controller_pkg.sv
// rtl/dijkstra_relax_controller_pkg.sv - shared widths, markers and FSM state encoding
package dijkstra_relax_controller_pkg;
   localparam int DEFAULT_MAX_NODES   = 4;
   localparam int DEFAULT_INDEX_WIDTH = 2;
   localparam int DEFAULT_VALUE_WIDTH = 8;

   localparam logic UNVISITED = 1'b0;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      SELECT,
      FETCH,
      RELAX,
      DONE
   } state_e;
endpackage

// File: rtl/dijkstra_relax_controller_pred_table.sv
// rtl/dijkstra_relax_controller_pred_table.sv - predecessor register file, init-all or write-one
module dijkstra_relax_controller_pred_table
   import dijkstra_relax_controller_pkg::*;
#(
   parameter int MAX_NODES   = DEFAULT_MAX_NODES,
   parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   init_all,
   input  logic [INDEX_WIDTH-1:0] init_value,
   input  logic                   wr_en,
   input  logic [INDEX_WIDTH-1:0] wr_index,
   input  logic [INDEX_WIDTH-1:0] wr_value,
   input  logic [INDEX_WIDTH-1:0] rd_index,
   output logic [INDEX_WIDTH-1:0] rd_value
);

   logic [INDEX_WIDTH-1:0] entries_q [MAX_NODES];
   logic [INDEX_WIDTH-1:0] entries_d [MAX_NODES];

   always_comb begin
      entries_d = entries_q;
      if (init_all) begin
         for (int i = 0; i < MAX_NODES; i++) begin
            entries_d[i] = init_value;
         end
      end else if (wr_en) begin
         entries_d[wr_index] = wr_value;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         entries_q <= '{default: '0};
      end else begin
         entries_q <= entries_d;
      end
   end

   assign rd_value = entries_q[rd_index];

endmodule

// File: rtl/dijkstra_relax_controller.sv
// rtl/dijkstra_relax_controller.sv - Dijkstra round sequencer: select min node, relax its row
module dijkstra_relax_controller
   import dijkstra_relax_controller_pkg::*;
#(
   parameter int MAX_NODES   = DEFAULT_MAX_NODES,
   parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
   parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [INDEX_WIDTH-1:0] source,
   output logic                   busy,
   output logic                   done,
   output logic [INDEX_WIDTH-1:0] adj_row,
   output logic [INDEX_WIDTH-1:0] adj_col,
   input  logic [VALUE_WIDTH-1:0] adj_weight,
   output logic                   pq_init,
   output logic                   pq_set_en,
   output logic [INDEX_WIDTH-1:0] pq_index,
   output logic [VALUE_WIDTH-1:0] pq_write_value,
   input  logic [VALUE_WIDTH-1:0] pq_read_value,
   input  logic [INDEX_WIDTH-1:0] pq_min_index,
   input  logic [VALUE_WIDTH-1:0] pq_min_value,
   output logic [MAX_NODES-1:0]   visited_vector,
   input  logic [INDEX_WIDTH-1:0] pred_index,
   output logic [INDEX_WIDTH-1:0] pred_value
);

   localparam logic [VALUE_WIDTH-1:0] INFINITY  = '1;
   localparam logic [INDEX_WIDTH-1:0] LAST_NODE = INDEX_WIDTH'(MAX_NODES - 1);

   state_e                 state_q, state_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   pq_init_q, pq_init_d;
   logic [INDEX_WIDTH-1:0] pq_index_q, pq_index_d;
   logic [INDEX_WIDTH-1:0] adj_row_q, adj_row_d;
   logic [INDEX_WIDTH-1:0] adj_col_q, adj_col_d;
   logic [INDEX_WIDTH-1:0] src_q, src_d;
   logic [INDEX_WIDTH-1:0] cur_q, cur_d;
   logic [INDEX_WIDTH-1:0] nbr_q, nbr_d;
   logic [VALUE_WIDTH-1:0] cur_dist_q, cur_dist_d;
   logic [MAX_NODES-1:0]   visited_q, visited_d;
   logic [VALUE_WIDTH:0]   sum;
   logic                   relax_write;

   // Weight arrives one cycle after FETCH, so the write decision is made combinationally in RELAX.
   always_comb begin
      sum         = {1'b0, cur_dist_q} + {1'b0, adj_weight};
      relax_write = (state_q == RELAX) && (visited_q[nbr_q] == UNVISITED) &&
                    (adj_weight != INFINITY) && (sum < {1'b0, INFINITY}) &&
                    (sum < {1'b0, pq_read_value});
   end

   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      pq_init_d  = 1'b0;
      pq_index_d = pq_index_q;
      adj_row_d  = adj_row_q;
      adj_col_d  = adj_col_q;
      src_d      = src_q;
      cur_d      = cur_q;
      nbr_d      = nbr_q;
      cur_dist_d = cur_dist_q;
      visited_d  = visited_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = INIT;
               src_d      = source;
               busy_d     = 1'b1;
               pq_init_d  = 1'b1;
               pq_index_d = source;
               visited_d  = {MAX_NODES{UNVISITED}};
            end
         end
         INIT: state_d = SELECT;
         SELECT: begin
            if ((&visited_q) || (pq_min_value == INFINITY)) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               state_d                 = FETCH;
               cur_d                   = pq_min_index;
               cur_dist_d              = pq_min_value;
               visited_d[pq_min_index] = ~UNVISITED;
               nbr_d                   = '0;
               adj_row_d               = pq_min_index;
               adj_col_d               = '0;
            end
         end
         FETCH: begin
            state_d    = RELAX;
            pq_index_d = nbr_q;
         end
         RELAX: begin
            if (nbr_q == LAST_NODE) begin
               state_d = SELECT;
            end else begin
               state_d   = FETCH;
               nbr_d     = nbr_q + 1'b1;
               adj_col_d = nbr_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pq_init_q  <= 1'b0;
         pq_index_q <= '0;
         adj_row_q  <= '0;
         adj_col_q  <= '0;
         src_q      <= '0;
         cur_q      <= '0;
         nbr_q      <= '0;
         cur_dist_q <= '0;
         visited_q  <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pq_init_q  <= pq_init_d;
         pq_index_q <= pq_index_d;
         adj_row_q  <= adj_row_d;
         adj_col_q  <= adj_col_d;
         src_q      <= src_d;
         cur_q      <= cur_d;
         nbr_q      <= nbr_d;
         cur_dist_q <= cur_dist_d;
         visited_q  <= visited_d;
      end
   end

   dijkstra_relax_controller_pred_table #(
      .MAX_NODES  (MAX_NODES),
      .INDEX_WIDTH(INDEX_WIDTH)
   ) u_pred_table (
      .clock     (clock),
      .reset     (reset),
      .init_all  (state_q == INIT),
      .init_value(src_q),
      .wr_en     (relax_write),
      .wr_index  (nbr_q),
      .wr_value  (cur_q),
      .rd_index  (pred_index),
      .rd_value  (pred_value)
   );

   assign busy           = busy_q;
   assign done           = done_q;
   assign pq_init        = pq_init_q;
   assign pq_index       = pq_index_q;
   assign adj_row        = adj_row_q;
   assign adj_col        = adj_col_q;
   assign visited_vector = visited_q;
   assign pq_set_en      = relax_write;
   assign pq_write_value = relax_write ? sum[VALUE_WIDTH-1:0] : '0;

endmodule
